// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchroniser, debouncer, press/release strobes
// and hold/auto-repeat engine for push-button inputs.
module button_conditioner #(
  parameter int CHANNELS      = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 10,
  parameter int REPEAT_CYCLES = 3,
  parameter int REPEAT_EN     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] rel,
  output logic [CHANNELS-1:0] rpt
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW = $clog2(HMAX + 1);
  localparam logic [CW-1:0] C_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] R_LAST = HW'(REPEAT_CYCLES - 1);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync;

  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], in};

  for (genvar i = 0; i < CHANNELS; i++) begin : ch
    logic [CW-1:0] cnt;
    logic [HW-1:0] hcnt;
    logic phase, l, p, r, q, s, accept, nl;
    assign s = sync[SYNC_STAGES-1][i];
    assign accept = (s != l) && (cnt == C_LAST);
    assign nl = accept ? s : l;
    assign level[i] = l;
    assign press[i] = p;
    assign rel[i] = r;
    assign rpt[i] = q;
    // The hold engine only runs while the level stays high across the edge,
    // so rpt can never coincide with press or release.
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        l <= 1'b0;
        cnt <= '0;
        p <= 1'b0;
        r <= 1'b0;
        q <= 1'b0;
        hcnt <= '0;
        phase <= 1'b0;
      end else begin
        l <= nl;
        cnt <= (s == l || accept) ? '0 : cnt + 1'b1;
        p <= nl & ~l;
        r <= ~nl & l;
        if (!nl || !l) begin
          hcnt <= '0;
          phase <= 1'b0;
          q <= 1'b0;
        end else if (!phase) begin
          q <= hcnt == H_LAST;
          phase <= hcnt == H_LAST;
          hcnt <= (hcnt == H_LAST) ? '0 : hcnt + 1'b1;
        end else if (REPEAT_EN != 0) begin
          q <= hcnt == R_LAST;
          hcnt <= (hcnt == R_LAST) ? '0 : hcnt + 1'b1;
        end else begin
          q <= 1'b0;
        end
      end
  end
endmodule
